// File: rtl/rt_req_ctl.sv
// Routing-request controller: parks per-VC directions, presents one WAIT VC at a time to the VC allocator, holds the path until tail.
// va_req follows acceptance by one edge; an offered request is frozen until granted. RT_WDOG_EN adds a sticky per-VC wait watchdog (rt_err).
module rt_req_ctl #(
  parameter int VCN    = 2,
  parameter int SN     = 4,
  parameter int WDOG_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [VCN-1:0]    rt_valid,
  input  logic [VCN*SN-1:0] rt_dir,
  output logic [VCN-1:0]    rt_ready,
  output logic              va_req,
  output logic [VCN-1:0]    va_vc,
  output logic [SN-1:0]     va_dir,
  input  logic              va_gnt,
  input  logic [VCN-1:0]    tail_done,
  output logic [VCN-1:0]    vc_active,
  output logic [VCN*SN-1:0] sw_dir,
  output logic [VCN-1:0]    rt_err
);
  localparam int PW = (VCN > 1) ? $clog2(VCN) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACTIVE} st_t;

  if (VCN < 1 || SN < 1 || WDOG_W < 1) begin : g_bad_param
    $error("rt_req_ctl: VCN, SN and WDOG_W must all be at least 1");
  end

  st_t           st_q  [VCN];
  st_t           st_d  [VCN];
  logic [SN-1:0] dir_q [VCN];
  logic [SN-1:0] dir_d [VCN];
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PW-1:0] sel_q, sel_d;
  logic [PW-1:0] rr_idx, sel_idx;
  logic          lock_q, lock_d;
  logic          rr_found, gnt_ok;

  always_comb begin : next_state
    int idx_i;
    int nxt_i;
    idx_i     = 0;
    nxt_i     = 0;
    rr_found  = 1'b0;
    rr_idx    = '0;
    st_d      = st_q;
    dir_d     = dir_q;
    rr_ptr_d  = rr_ptr_q;
    sel_d     = sel_q;
    lock_d    = lock_q;
    rt_ready  = '0;
    vc_active = '0;
    sw_dir    = '0;
    va_vc     = '0;

    // First WAIT VC at or after the pointer, wrapping.
    for (int i = 0; i < VCN; i++) begin
      idx_i = int'(rr_ptr_q) + i;
      if (idx_i >= VCN) idx_i = idx_i - VCN;
      if (!rr_found && st_q[PW'(idx_i)] == ST_WAIT) begin
        rr_found = 1'b1;
        rr_idx   = PW'(idx_i);
      end
    end

    sel_idx = lock_q ? sel_q : rr_idx;
    va_req  = lock_q | rr_found;
    va_dir  = va_req ? dir_q[sel_idx] : '0;
    gnt_ok  = va_req & va_gnt;

    for (int v = 0; v < VCN; v++) begin
      rt_ready[v]           = (st_q[v] == ST_IDLE);
      vc_active[v]          = (st_q[v] == ST_ACTIVE);
      sw_dir[v*SN +: SN]    = (st_q[v] == ST_ACTIVE) ? dir_q[v] : '0;
      va_vc[v]              = va_req && (sel_idx == PW'(v));
      unique case (st_q[v])
        ST_IDLE: if (rt_valid[v]) begin
          st_d[v]  = ST_WAIT;
          dir_d[v] = rt_dir[v*SN +: SN];
        end
        ST_WAIT:   if (gnt_ok && sel_idx == PW'(v)) st_d[v] = ST_ACTIVE;
        ST_ACTIVE: if (tail_done[v]) st_d[v] = ST_IDLE;
        default:   st_d[v] = ST_IDLE;
      endcase
    end

    // An unanswered request freezes the selection; a grant releases it and advances the pointer.
    if (gnt_ok) begin
      lock_d = 1'b0;
      nxt_i  = int'(sel_idx) + 1;
      if (nxt_i >= VCN) nxt_i = 0;
      rr_ptr_d = PW'(nxt_i);
    end else if (va_req) begin
      lock_d = 1'b1;
      sel_d  = sel_idx;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int v = 0; v < VCN; v++) begin
        st_q[v]  <= ST_IDLE;
        dir_q[v] <= '0;
      end
      rr_ptr_q <= '0;
      sel_q    <= '0;
      lock_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      dir_q    <= dir_d;
      rr_ptr_q <= rr_ptr_d;
      sel_q    <= sel_d;
      lock_q   <= lock_d;
    end
  end

`ifdef RT_WDOG_EN
  localparam logic [WDOG_W-1:0] WdogMax = '1;

  logic [WDOG_W-1:0] wd_cnt_q [VCN];
  logic [WDOG_W-1:0] wd_cnt_d [VCN];
  logic [VCN-1:0]    err_q, err_d;

  always_comb begin : wdog
    wd_cnt_d = wd_cnt_q;
    err_d    = err_q;
    for (int v = 0; v < VCN; v++) begin
      if (st_q[v] == ST_IDLE && rt_valid[v]) begin
        wd_cnt_d[v] = '0;
      end else if (st_q[v] == ST_WAIT && wd_cnt_q[v] != WdogMax) begin
        wd_cnt_d[v] = wd_cnt_q[v] + WDOG_W'(1);
      end
      if (wd_cnt_d[v] == WdogMax) err_d[v] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int v = 0; v < VCN; v++) wd_cnt_q[v] <= '0;
      err_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
    end
  end

  assign rt_err = err_q;
`else
  assign rt_err = '0;
`endif

endmodule

// File: tb/tb_rt_req_ctl.sv
// Bench for rt_req_ctl: directed scenarios plus random traffic against a rule-level reference model.
`timescale 1ns/1ps
module tb_rt_req_ctl;
  localparam int VCN = 2;
  localparam int SN  = 4;
`ifdef RT_WDOG_EN
  localparam int WD = 4;
`else
  localparam int WD = 8;
`endif
  localparam int WMAX = (1 << WD) - 1;
  localparam int M_IDLE = 0, M_WAIT = 1, M_ACT = 2;

  logic              clk = 1'b0;
  logic              rstn;
  logic [VCN-1:0]    rt_valid;
  logic [VCN*SN-1:0] rt_dir;
  logic [VCN-1:0]    rt_ready;
  logic              va_req;
  logic [VCN-1:0]    va_vc;
  logic [SN-1:0]     va_dir;
  logic              va_gnt;
  logic [VCN-1:0]    tail_done;
  logic [VCN-1:0]    vc_active;
  logic [VCN*SN-1:0] sw_dir;
  logic [VCN-1:0]    rt_err;

  rt_req_ctl #(.VCN(VCN), .SN(SN), .WDOG_W(WD)) dut (
    .clk(clk), .rstn(rstn), .rt_valid(rt_valid), .rt_dir(rt_dir), .rt_ready(rt_ready),
    .va_req(va_req), .va_vc(va_vc), .va_dir(va_dir), .va_gnt(va_gnt),
    .tail_done(tail_done), .vc_active(vc_active), .sw_dir(sw_dir), .rt_err(rt_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per-VC state, stored direction, pointer, frozen selection, watchdog.
  int            m_st   [VCN];
  logic [SN-1:0] m_dir  [VCN];
  int            m_cnt  [VCN];
  bit            m_err  [VCN];
  int            m_ptr;
  bit            m_lock;
  int            m_sel;

  task automatic m_reset();
    for (int v = 0; v < VCN; v++) begin
      m_st[v] = M_IDLE; m_dir[v] = '0; m_cnt[v] = 0; m_err[v] = 0;
    end
    m_ptr = 0; m_lock = 0; m_sel = 0;
  endtask

  function automatic int m_pick();
    if (m_lock) return m_sel;
    for (int i = 0; i < VCN; i++)
      if (m_st[(m_ptr + i) % VCN] == M_WAIT) return (m_ptr + i) % VCN;
    return -1;
  endfunction

  task automatic check_outputs();
    int s = m_pick();
    logic [VCN-1:0]    e_rdy, e_act, e_vc, e_err;
    logic [VCN*SN-1:0] e_sw;
    logic [SN-1:0]     e_vd;
    e_vd = (s >= 0) ? m_dir[s] : '0;
    for (int v = 0; v < VCN; v++) begin
      e_rdy[v] = (m_st[v] == M_IDLE);
      e_act[v] = (m_st[v] == M_ACT);
      e_vc[v]  = (s == v);
      e_sw[v*SN +: SN] = (m_st[v] == M_ACT) ? m_dir[v] : '0;
`ifdef RT_WDOG_EN
      e_err[v] = m_err[v];
`else
      e_err[v] = 1'b0;
`endif
    end
    check("rt_ready",  32'(rt_ready),  32'(e_rdy));
    check("va_req",    32'(va_req),    32'(s >= 0));
    check("va_vc",     32'(va_vc),     32'(e_vc));
    check("va_dir",    32'(va_dir),    32'(e_vd));
    check("vc_active", 32'(vc_active), 32'(e_act));
    check("sw_dir",    32'(sw_dir),    32'(e_sw));
    check("rt_err",    32'(rt_err),    32'(e_err));
  endtask

  task automatic model_edge();
    int s = m_pick();
    for (int v = 0; v < VCN; v++) begin
      if (m_st[v] == M_WAIT && m_cnt[v] < WMAX) m_cnt[v]++;
      if (m_st[v] == M_IDLE && rt_valid[v]) m_cnt[v] = 0;
      if (m_cnt[v] == WMAX) m_err[v] = 1;
      if (m_st[v] == M_IDLE && rt_valid[v]) begin
        m_st[v] = M_WAIT; m_dir[v] = rt_dir[v*SN +: SN];
      end else if (m_st[v] == M_WAIT && s == v && va_gnt) begin
        m_st[v] = M_ACT;
      end else if (m_st[v] == M_ACT && tail_done[v]) begin
        m_st[v] = M_IDLE;
      end
    end
    if (s >= 0) begin
      if (va_gnt) begin m_ptr = (s + 1) % VCN; m_lock = 0; end
      else begin m_lock = 1; m_sel = s; end
    end
  endtask

  // One clock: drive, compare mid-cycle, advance the model at the edge, settle.
  task automatic tick(input logic [VCN-1:0] v, input logic [VCN*SN-1:0] d,
                      input logic g, input logic [VCN-1:0] t);
    rt_valid = v; rt_dir = d; va_gnt = g; tail_done = t;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    #2 rstn = 1'b0;
    #1;
    check("rst_vc_active", 32'(vc_active), 32'd0);
    check("rst_sw_dir",    32'(sw_dir),    32'd0);
    check("rst_va_req",    32'(va_req),    32'd0);
    check("rst_rt_err",    32'(rt_err),    32'd0);
    m_reset();
    @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; rt_valid = '0; rt_dir = '0; va_gnt = 1'b0; tail_done = '0;
    m_reset();
    #12;
    check("por_va_req",    32'(va_req),    32'd0);
    check("por_va_vc",     32'(va_vc),     32'd0);
    check("por_vc_active", 32'(vc_active), 32'd0);
    check("por_sw_dir",    32'(sw_dir),    32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (10) tick('0, '0, 1'b0, '0);

    // Simultaneous pair with pointer at 0: VC0 first.
    tick(2'b11, 8'h81, 1'b0, '0);
    check("rr1_vc",  32'(va_vc),  32'h1);
    check("rr1_dir", 32'(va_dir), 32'h1);
    tick('0, '0, 1'b1, '0);
    check("rr1_act",  32'(vc_active), 32'h1);
    check("rr1_vc2",  32'(va_vc),     32'h2);
    check("rr1_dir2", 32'(va_dir),    32'h8);
    tick('0, '0, 1'b1, '0);
    check("rr1_sw", 32'(sw_dir), 32'h81);
    tick('0, '0, 1'b0, 2'b11);
    check("rr1_rdy", 32'(rt_ready), 32'h3);

    // Single packet on VC0.
    tick(2'b01, 8'h04, 1'b0, '0);
    check("pkt_req", 32'(va_req), 32'h1);
    check("pkt_vc",  32'(va_vc),  32'h1);
    check("pkt_dir", 32'(va_dir), 32'h4);
    tick('0, '0, 1'b1, '0);
    check("pkt_act", 32'(vc_active), 32'h1);
    check("pkt_sw",  32'(sw_dir),    32'h04);
    tick('0, '0, 1'b0, 2'b01);
    check("pkt_rdy", 32'(rt_ready), 32'h3);

    // Second pair with pointer at 1: VC1 first.
    tick(2'b11, 8'h81, 1'b0, '0);
    check("rr2_vc",  32'(va_vc),  32'h2);
    check("rr2_dir", 32'(va_dir), 32'h8);
    tick('0, '0, 1'b1, '0);
    check("rr2_act", 32'(vc_active), 32'h2);
    tick('0, '0, 1'b1, '0);
    tick('0, '0, 1'b0, 2'b11);

    // Stray tail and stray grant change nothing.
    tick('0, '0, 1'b0, 2'b10);
    tick('0, '0, 1'b1, '0);
    check("ign_req", 32'(va_req),    32'h0);
    check("ign_act", 32'(vc_active), 32'h0);
    check("ign_rdy", 32'(rt_ready),  32'h3);

    // Reset while VC0 is active.
    tick(2'b01, 8'h04, 1'b0, '0);
    tick('0, '0, 1'b1, '0);
    check("mid_act", 32'(vc_active), 32'h1);
    do_reset();

    // Lock: VC1 offered and refused, then VC0 arrives with the pointer favouring it.
    tick(2'b10, 8'h20, 1'b0, '0);
    repeat (5) tick('0, '0, 1'b0, '0);
    tick(2'b01, 8'h01, 1'b0, '0);
    repeat (3) tick('0, '0, 1'b0, '0);
    check("lock_vc",  32'(va_vc),  32'h2);
    check("lock_dir", 32'(va_dir), 32'h2);
    tick('0, '0, 1'b1, '0);
    check("lock_act", 32'(vc_active), 32'h2);
    check("lock_vc0", 32'(va_vc),     32'h1);

    // VC0 left waiting long enough to saturate a 4-bit watchdog.
    repeat (16) tick('0, '0, 1'b0, '0);
`ifdef RT_WDOG_EN
    check("wdog_err", 32'(rt_err[0]), 32'h1);
`else
    check("wdog_err", 32'(rt_err), 32'h0);
`endif
    tick('0, '0, 1'b1, '0);
    check("wdog_act", 32'(vc_active), 32'h3);
`ifdef RT_WDOG_EN
    check("wdog_sticky", 32'(rt_err[0]), 32'h1);
`endif
    tick('0, '0, 1'b0, 2'b11);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      tick(2'($urandom_range(0, 3)), 8'($urandom), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rt_req_ctl.md
Name: rt_req_ctl

Overview:
- Clocked routing-request controller; sits directly downstream of the input-buffer routing-calculation unit.
- Per VC, accepts the one-hot output-direction request, parks it until the VC allocator grants, then holds the direction for the switch while the packet streams.
- Releases on tail departure. A round-robin stage presents one pending VC at a time to the allocator.

Parameters:
- VCN, 2, number of virtual channels per input port
- SN, 4, width of the one-hot direction vector (output ports reachable from this input)
- WDOG_W, 8, width of the per-VC wait watchdog counter (used only with RT_WDOG_EN)

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- rt_valid  in  VCN  per-VC routing result valid
- rt_dir  in  VCN*SN  per-VC one-hot direction; VC v occupies bits [v*SN +: SN]
- rt_ready  out  VCN  per-VC accept; high only in IDLE
- va_req  out  1  request to VC allocator
- va_vc  out  VCN  one-hot: which input VC is requesting
- va_dir  out  SN  direction of the requesting VC
- va_gnt  in  1  allocator grant for the presented request; single-cycle pulse
- tail_done  in  VCN  per-VC pulse: tail flit of the active packet has left the switch
- vc_active  out  VCN  VC holds an allocated path
- sw_dir  out  VCN*SN  held direction per VC; zero when the VC is not ACTIVE
- rt_err  out  VCN  sticky watchdog error (see Optional Feature)

Behaviour:
- Reset (rstn low, async): all VC FSMs IDLE, rr pointer=0, lock=0, stored dirs=0.
- Reset output values: rt_ready=all 1 once rstn released (combinational from IDLE); va_req=0, va_vc=0, va_dir=0, vc_active=0, sw_dir=0, rt_err=0.
- Per-VC FSM, 3 states:
  - IDLE: rt_ready[v]=1. On rt_valid[v] at clk edge, capture rt_dir[v] and go to WAIT.
  - WAIT: eligible for arbitration. When va_gnt arrives while this VC is selected, go to ACTIVE.
  - ACTIVE: vc_active[v]=1, sw_dir[v]=stored dir. On tail_done[v], go to IDLE.
- Minimum latency: rt_valid accepted at edge N; va_req visible after edge N (same cycle as WAIT). Earliest ACTIVE is edge N+1 if va_gnt is high in that cycle.
- Arbitration:
  - Round-robin over WAIT VCs, starting search at pointer.
  - When lock=0: selection is combinational; va_req=|WAIT.
  - When va_req=1 and va_gnt=0 at an edge: lock=1 and the selection is frozen. va_vc and va_dir stay stable until grant. No withdrawal; a newly arriving WAIT VC never preempts.
  - On va_gnt: selected VC goes to ACTIVE, pointer=(sel+1) mod VCN, lock=0.
  - va_gnt while va_req=0: ignored.
- tail_done[v] while not ACTIVE: ignored. A VC returning to IDLE accepts rt_valid only on the following cycle (rt_ready is state-based, no bypass).
- Direction is stored verbatim; a zero or multi-hot direction is not checked and is passed through.
- Reset mid-operation: all in-flight WAIT/ACTIVE state is discarded immediately; outputs go to reset values asynchronously.

Optional Feature:
- Macro: RT_WDOG_EN.
- Defined:
  - Per-VC WDOG_W-bit counter clears on entry to WAIT and increments each cycle in WAIT, saturating at 2^WDOG_W-1.
  - When the count reaches saturation, rt_err[v] sets and stays set until reset. The FSM is unaffected.
- Undefined: no counters; rt_err tied to 0.

Test Plan:
- Reset then idle: rstn 0->1, no stimulus -> rt_ready=2'b11, va_req=0, vc_active=0, sw_dir=0 for 10 cycles.
- Single packet: VC0 rt_valid with dir=4'b0100 -> next cycle va_req=1, va_vc=01, va_dir=0100; va_gnt one cycle -> vc_active=01, sw_dir[3:0]=0100; tail_done[0] -> IDLE, rt_ready[0]=1.
- Round-robin fairness: VC0 dir 0001 and VC1 dir 1000 both valid in the same cycle, pointer=0 -> VC0 granted first, then va_vc=10, va_dir=1000; a second pair after release -> VC1 granted first.
- Lock stability: VC1 waiting with va_gnt held low 5 cycles, then VC0 arrives -> va_vc stays 10 and va_dir stays unchanged until the grant.
- Ignored events: tail_done[1] while VC1 is IDLE, and va_gnt with va_req=0 -> no state change.
- Reset mid-packet, then watchdog: assert rstn low while VC0 is ACTIVE -> vc_active=0 immediately. With RT_WDOG_EN and WDOG_W=4, VC0 waits ungranted 15 cycles -> rt_err[0]=1, stays 1 after grant.
